// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command handshake and ALU operand/result bus for alu_sequencer
interface alu_sequencer_if #(
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_ld;
    logic          cmd_arit;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [AW-1:0] cmd_rd;
    logic [3:0]    cmd_imm;
    logic [1:0]    cmd_cond;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [1:0]    alu_op;
    logic          alu_arit;
    logic [3:0]    alu_r;
    logic          alu_z;
    logic          alu_c;
    logic          alu_s;

    // master: instruction source plus the ALU it drives; slave: the sequencer
    modport master (
        output cmd_valid, cmd_ld, cmd_arit, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, cmd_cond,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op, alu_arit,
        output alu_r, alu_z, alu_c, alu_s
    );

    modport slave (
        input  cmd_valid, cmd_ld, cmd_arit, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm, cmd_cond,
        output cmd_ready,
        output alu_a, alu_b, alu_op, alu_arit,
        input  alu_r, alu_z, alu_c, alu_s
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer for the 4-bit ALU over a small register file
// Optional conditional execution enabled by defining ALU_SEQ_COND_EN.
module alu_sequencer #(
    parameter int NREG     = 4,
    parameter int AW       = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_sequencer_if.slave bus,
    output logic          done,
    output logic          done_skip,
    output logic [3:0]    res,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_s,
    input  logic [AW-1:0] dbg_addr,
    output logic [3:0]    dbg_data
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

    state_t        state_q;
    logic [3:0]    regs_q [NREG];
    logic [AW-1:0] rd_q;
    logic [3:0]    cnt_q;
    logic          ready_q;
    logic          done_q;
    logic [3:0]    res_q;
    logic          flag_z_q, flag_c_q, flag_s_q;
    logic [3:0]    alu_a_q, alu_b_q;
    logic [1:0]    alu_op_q;
    logic          alu_arit_q;
    logic          cond_ok;

`ifdef ALU_SEQ_COND_EN
    logic skip_q;

    always_comb begin
        case (bus.cmd_cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = flag_z_q;
            2'b10:   cond_ok = flag_c_q;
            default: cond_ok = flag_s_q;
        endcase
    end

    // A suppressed command goes IDLE -> DONE, so the skip pulse aligns with done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= (state_q == IDLE) && bus.cmd_valid && !cond_ok;
        end
    end

    assign done_skip = skip_q;
`else
    logic unused_cond;

    assign cond_ok     = 1'b1;
    assign done_skip   = 1'b0;
    assign unused_cond = ^bus.cmd_cond;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_q       <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_s_q   <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_arit_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (!cond_ok) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (bus.cmd_ld) begin
                            regs_q[bus.cmd_rd] <= bus.cmd_imm;
                            res_q              <= bus.cmd_imm;
                            state_q            <= DONE;
                            done_q             <= 1'b1;
                        end else begin
                            // Operands are read here, so later writes to rd cannot disturb them
                            alu_a_q    <= regs_q[bus.cmd_ra];
                            alu_b_q    <= regs_q[bus.cmd_rb];
                            alu_op_q   <= bus.cmd_op;
                            alu_arit_q <= bus.cmd_arit;
                            rd_q       <= bus.cmd_rd;
                            cnt_q      <= WAIT_INIT;
                            state_q    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        regs_q[rd_q] <= bus.alu_r;
                        res_q        <= bus.alu_r;
                        flag_z_q     <= bus.alu_z;
                        // Carry is only meaningful for add; logic ops leave C and S alone
                        if (alu_arit_q) begin
                            flag_s_q <= bus.alu_s;
                            if (alu_op_q == 2'b00) begin
                                flag_c_q <= bus.alu_c;
                            end
                        end
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_arit  = alu_arit_q;
    assign done          = done_q;
    assign res           = res_q;
    assign flag_z        = flag_z_q;
    assign flag_c        = flag_c_q;
    assign flag_s        = flag_s_q;
    assign dbg_data      = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized and directed bench for alu_sequencer (ALU_WAIT=1 and ALU_WAIT=3)
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       c_ld = 1'b0, c_arit = 1'b0;
    logic [1:0] c_op = '0, c_ra = '0, c_rb = '0, c_rd = '0, c_cond = '0;
    logic [3:0] c_imm = '0;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0] dbg_addr = '0;

    logic       done_a, skip_a, fz_a, fc_a, fs_a;
    logic       done_b, skip_b, fz_b, fc_b, fs_b;
    logic [3:0] res_a, dbg_a, res_b, dbg_b;

    alu_sequencer_if #(.AW(2)) ifa ();
    alu_sequencer_if #(.AW(2)) ifb ();

    assign ifa.cmd_valid = valid_a;
    assign ifb.cmd_valid = valid_b;
    assign ifa.cmd_ld = c_ld;     assign ifb.cmd_ld = c_ld;
    assign ifa.cmd_arit = c_arit; assign ifb.cmd_arit = c_arit;
    assign ifa.cmd_op = c_op;     assign ifb.cmd_op = c_op;
    assign ifa.cmd_ra = c_ra;     assign ifb.cmd_ra = c_ra;
    assign ifa.cmd_rb = c_rb;     assign ifb.cmd_rb = c_rb;
    assign ifa.cmd_rd = c_rd;     assign ifb.cmd_rd = c_rd;
    assign ifa.cmd_imm = c_imm;   assign ifb.cmd_imm = c_imm;
    assign ifa.cmd_cond = c_cond; assign ifb.cmd_cond = c_cond;

    alu_sequencer #(.NREG(4), .AW(2), .ALU_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .done(done_a), .done_skip(skip_a), .res(res_a),
        .flag_z(fz_a), .flag_c(fc_a), .flag_s(fs_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
    );

    alu_sequencer #(.NREG(4), .AW(2), .ALU_WAIT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .done(done_b), .done_skip(skip_b), .res(res_b),
        .flag_z(fz_b), .flag_c(fc_b), .flag_s(fs_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
    );

    // Arithmetic on plain integers; bit 4 is the add carry-out
    function automatic logic [4:0] ref_op(input logic arit, input logic [1:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
        int x, y, v;
        x = int'(a);
        y = int'(b);
        if (arit) begin
            case (op)
                2'd0:    v = x + y;
                2'd1:    v = x - y;
                2'd2:    v = -x;
                default: v = -y;
            endcase
        end else begin
            case (op)
                2'd0:    v = x & y;
                2'd1:    v = x | y;
                2'd2:    v = x ^ y;
                default: v = ~x;
            endcase
        end
        return 5'(v);
    endfunction

    // Stand-in ALU: drives junk on the flags the sequencer must ignore
    function automatic logic [6:0] alu_fn(input logic arit, input logic [1:0] op,
                                          input logic [3:0] a, input logic [3:0] b);
        logic [4:0] v;
        logic       c, s;
        v = ref_op(arit, op, a, b);
        if (arit) begin
            s = v[3];
            c = (op == 2'd0) ? v[4] : ~v[4];
        end else begin
            s = 1'b1;
            c = 1'b1;
        end
        return {c, s, (v[3:0] == 4'd0), v[3:0]};
    endfunction

    assign {ifa.alu_c, ifa.alu_s, ifa.alu_z, ifa.alu_r} = alu_fn(ifa.alu_arit, ifa.alu_op, ifa.alu_a, ifa.alu_b);
    assign {ifb.alu_c, ifb.alu_s, ifb.alu_z, ifb.alu_r} = alu_fn(ifb.alu_arit, ifb.alu_op, ifb.alu_a, ifb.alu_b);

    logic [3:0] m_reg [2][4];
    logic [3:0] m_res [2];
    logic       m_z [2], m_c [2], m_s [2];
    int checks = 0;
    int errors = 0;

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) m_reg[s][i] = '0;
            m_res[s] = '0;
            m_z[s] = 1'b0; m_c[s] = 1'b0; m_s[s] = 1'b0;
        end
    endtask

    // One command through DUT s (0: ALU_WAIT=1, 1: ALU_WAIT=3), checked against the model
    task automatic do_cmd(input bit s, input logic ld, input logic arit, input logic [1:0] op,
                          input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                          input logic [3:0] imm, input logic [1:0] cond);
        logic       ok;
        logic [4:0] v;
        int         n, exp_n;
        ok = 1'b1;
`ifdef ALU_SEQ_COND_EN
        case (cond)
            2'd1:    ok = m_z[s];
            2'd2:    ok = m_c[s];
            2'd3:    ok = m_s[s];
            default: ok = 1'b1;
        endcase
`endif
        if (!ok || ld) exp_n = 1;
        else exp_n = (s ? 3 : 1) + 1;
        if (ok && ld) begin
            m_reg[s][rd] = imm;
            m_res[s] = imm;
        end else if (ok) begin
            v = ref_op(arit, op, m_reg[s][ra], m_reg[s][rb]);
            m_reg[s][rd] = v[3:0];
            m_res[s] = v[3:0];
            m_z[s] = (v[3:0] == 4'd0);
            if (arit) begin
                m_s[s] = v[3];
                if (op == 2'd0) m_c[s] = v[4];
            end
        end
        @(negedge clk);
        c_ld = ld; c_arit = arit; c_op = op; c_ra = ra; c_rb = rb; c_rd = rd; c_imm = imm; c_cond = cond;
        valid_a = !s; valid_b = s;
        n = 0;
        while (!(s ? ifb.cmd_ready : ifa.cmd_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin errors++; $display("FAIL ready_timeout dut%0d got 0 exp 1", s); end
        @(posedge clk);
        #1 valid_a = 1'b0; valid_b = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s ? done_b : done_a) && n < 20);
        checks++;
        if (n !== exp_n) begin errors++; $display("FAIL latency dut%0d got %0d exp %0d", s, n, exp_n); end
        checks++;
        if ((s ? skip_b : skip_a) !== !ok) begin
            errors++; $display("FAIL done_skip dut%0d got %b exp %b", s, s ? skip_b : skip_a, !ok);
        end
        dbg_addr = rd;
        #1;
        checks++;
        if ((s ? res_b : res_a) !== m_res[s]) begin
            errors++; $display("FAIL res dut%0d got %h exp %h", s, s ? res_b : res_a, m_res[s]);
        end
        checks++;
        if ((s ? dbg_b : dbg_a) !== m_reg[s][rd]) begin
            errors++; $display("FAIL reg%0d dut%0d got %h exp %h", rd, s, s ? dbg_b : dbg_a, m_reg[s][rd]);
        end
        checks++;
        if ((s ? {fz_b, fc_b, fs_b} : {fz_a, fc_a, fs_a}) !== {m_z[s], m_c[s], m_s[s]}) begin
            errors++; $display("FAIL flags_zcs dut%0d got %b exp %b", s,
                               s ? {fz_b, fc_b, fs_b} : {fz_a, fc_a, fs_a}, {m_z[s], m_c[s], m_s[s]});
        end
        @(negedge clk);
        checks++;
        if ((s ? done_b : done_a) !== 1'b0) begin errors++; $display("FAIL done_width dut%0d got 1 exp 0", s); end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if ({ifa.cmd_ready, done_a, res_a, fz_a, fc_a, fs_a, ifa.alu_a, ifa.alu_b} !== {1'b1, 1'b0, 15'd0}) begin
            errors++; $display("FAIL reset_outputs got %b exp %b",
                {ifa.cmd_ready, done_a, res_a, fz_a, fc_a, fs_a, ifa.alu_a, ifa.alu_b}, {1'b1, 1'b0, 15'd0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b1010, 2'd0);
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1110, 2'd0);
        do_cmd(0, 0, 1, 2'd0, 2'd1, 2'd2, 2'd3, 4'd0, 2'd0);
        checks++;
        if ({res_a, fz_a, fc_a, fs_a} !== 7'b1000_011) begin
            errors++; $display("FAIL add_result got %b exp %b", {res_a, fz_a, fc_a, fs_a}, 7'b1000_011);
        end
    endtask

    task automatic test_sub();
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b1010, 2'd0);
        do_cmd(0, 0, 1, 2'd1, 2'd1, 2'd1, 2'd0, 4'd0, 2'd0);
        checks++;
        if ({res_a, fz_a, fc_a, fs_a} !== 7'b0000_110) begin
            errors++; $display("FAIL sub_result got %b exp %b", {res_a, fz_a, fc_a, fs_a}, 7'b0000_110);
        end
    endtask

    task automatic test_logic();
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'b1100, 2'd0);
        do_cmd(0, 0, 0, 2'd2, 2'd1, 2'd2, 2'd3, 4'd0, 2'd0);
        checks++;
        if (res_a !== 4'b0110) begin errors++; $display("FAIL xor_result got %b exp 0110", res_a); end
        do_cmd(0, 0, 0, 2'd3, 2'd1, 2'd2, 2'd0, 4'd0, 2'd0);
        checks++;
        if ({res_a, fz_a, fc_a, fs_a} !== 7'b0101_010) begin
            errors++; $display("FAIL nota_result got %b exp %b", {res_a, fz_a, fc_a, fs_a}, 7'b0101_010);
        end
    endtask

    task automatic test_reset_mid_exec();
        int pulses;
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 4'd9, 2'd0);
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'd8, 2'd0);
        do_cmd(0, 0, 1, 2'd0, 2'd1, 2'd2, 2'd3, 4'd0, 2'd0);
        @(negedge clk);
        c_ld = 1'b0; c_arit = 1'b1; c_op = 2'd0; c_ra = 2'd1; c_rb = 2'd2; c_rd = 2'd0; c_cond = 2'd0;
        valid_a = 1'b1;
        @(posedge clk);
        #1 valid_a = 1'b0;
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if ({ifa.cmd_ready, done_a, res_a, fz_a, fc_a, fs_a} !== {1'b1, 8'd0}) begin
            errors++; $display("FAIL midreset_outputs got %b exp %b", {ifa.cmd_ready, done_a, res_a, fz_a, fc_a, fs_a}, {1'b1, 8'd0});
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            checks++;
            if (dbg_a !== 4'd0) begin errors++; $display("FAIL midreset_reg%0d got %h exp 0", i, dbg_a); end
        end
        pulses = 0;
        repeat (2) begin @(negedge clk); pulses += int'(done_a); end
        reset = 1'b0;
        repeat (3) begin @(negedge clk); pulses += int'(done_a); end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_done got %0d exp 0", pulses); end
    endtask

    task automatic test_cond();
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'd7, 2'd1);
        do_cmd(0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'd5, 2'd0);
        do_cmd(0, 0, 1, 2'd0, 2'd2, 2'd2, 2'd1, 4'd0, 2'd3);
    endtask

    task automatic test_back_to_back();
        int         acc [$];
        int         n;
        logic [4:0] v;
        do_cmd(1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 4'b0011, 2'd0);
        do_cmd(1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd2, 4'b0101, 2'd0);
        @(negedge clk);
        c_ld = 1'b0; c_arit = 1'b1; c_op = 2'd0; c_ra = 2'd1; c_rb = 2'd2; c_rd = 2'd3; c_cond = 2'd0;
        valid_b = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (ifb.cmd_ready) acc.push_back(i);
            else begin
                checks++;
                if ({ifb.alu_a, ifb.alu_b, ifb.alu_op, ifb.alu_arit} !== {m_reg[1][1], m_reg[1][2], 2'd0, 1'b1}) begin
                    errors++; $display("FAIL alu_hold cyc%0d got %h exp %h", i,
                        {ifb.alu_a, ifb.alu_b, ifb.alu_op, ifb.alu_arit}, {m_reg[1][1], m_reg[1][2], 2'd0, 1'b1});
                end
            end
            @(negedge clk);
        end
        n = 0;
        while (!ifb.cmd_ready && n < 20) begin @(negedge clk); n++; end
        valid_b = 1'b0;
        v = ref_op(1'b1, 2'd0, m_reg[1][1], m_reg[1][2]);
        m_reg[1][3] = v[3:0]; m_res[1] = v[3:0]; m_z[1] = (v[3:0] == 4'd0); m_s[1] = v[3]; m_c[1] = v[4];
        checks++;
        if (acc.size() !== 6) begin errors++; $display("FAIL accept_count got %0d exp 6", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] !== 5) begin
                errors++; $display("FAIL accept_spacing idx%0d got %0d exp 5", i, acc[i] - acc[i-1]);
            end
        end
        dbg_addr = 2'd3;
        #1;
        checks++;
        if ({res_b, dbg_b, fz_b, fc_b, fs_b} !== {m_res[1], m_reg[1][3], m_z[1], m_c[1], m_s[1]}) begin
            errors++; $display("FAIL b2b_state got %b exp %b", {res_b, dbg_b, fz_b, fc_b, fs_b},
                               {m_res[1], m_reg[1][3], m_z[1], m_c[1], m_s[1]});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_cmd(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom),
                   2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_reset_mid_exec();
        test_cond();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
